// File: rtl/npcg_pm_pkg.sv
// Shared definitions for the BNC primitive-manager arbiter slice:
// FSM encodings, PM trigger bit positions, field widths and a one-hot helper.
package npcg_pm_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_BUSY    = 2'b01;
    localparam logic [1:0] ST_RELEASE = 2'b11;

    localparam int PM_BIT_PBR      = 6;
    localparam int PM_BIT_CMDISSUE = 3;
    localparam int PM_BIT_DI       = 1;
    localparam int PM_BIT_TIMER    = 0;

    localparam int PCMD_W     = 8;
    localparam int PCMD_OPT_W = 3;
    localparam int NUM_DATA_W = 16;

    // Index of the set bit of a one-hot vector (up to 8 requesters); 0 when empty.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/npcg_rr_picker.sv
// Combinational round-robin picker: first requester at or after the priority
// index, wrapping modulo N. Produces a one-hot pick and a valid flag.
module npcg_rr_picker
    import npcg_pm_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] iReq,
    input  logic [2:0]   iPriority,
    output logic [N-1:0] oPick,
    output logic         oValid
);

    // Scan the request vector starting at the priority index.
    always_comb begin
        int  idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        oPick = {N{1'b0}};
        for (int off = 0; off < N; off++) begin
            idx = (int'(iPriority) + off) % N;
            if (!found && iReq[idx]) begin
                oPick[idx] = 1'b1;
                found      = 1'b1;
            end else begin
                found = found;
            end
        end
        oValid = |iReq;
    end

endmodule

// File: rtl/npcg_toggle_bnc_pm_arbiter.sv
// Round-robin owner arbitration of one NAND primitive-manager port between
// BNC executors, with command, status and read muxing from the registered grant.
module npcg_toggle_bnc_pm_arbiter
    import npcg_pm_pkg::*;
#(
    parameter int NumberOfExecutors = 4,
    parameter int NumberOfWays      = 4
) (
    input  logic                                      iSystemClock,
    input  logic                                      iReset,
    input  logic [NumberOfExecutors-1:0]              iExReq,
    input  logic [NumberOfExecutors-1:0]              iExLastStep,
    output logic [NumberOfExecutors-1:0]              oExGrant,
    input  logic [PCMD_W*NumberOfExecutors-1:0]       iEx_PCommand,
    input  logic [PCMD_OPT_W*NumberOfExecutors-1:0]   iEx_PCommandOption,
    input  logic [NumberOfWays*NumberOfExecutors-1:0] iEx_TargetWay,
    input  logic [NUM_DATA_W*NumberOfExecutors-1:0]   iEx_NumOfData,
    input  logic [NumberOfExecutors-1:0]              iEx_CASelect,
    input  logic [8*NumberOfExecutors-1:0]            iEx_CAData,
    input  logic [NumberOfExecutors-1:0]              iEx_ReadReady,
    output logic [8*NumberOfExecutors-1:0]            oEx_PM_Ready,
    output logic [8*NumberOfExecutors-1:0]            oEx_PM_LastStep,
    output logic [31:0]                               oEx_ReadData,
    output logic [NumberOfExecutors-1:0]              oEx_ReadValid,
    output logic [NumberOfExecutors-1:0]              oEx_ReadLast,
    output logic [PCMD_W-1:0]                         oPM_PCommand,
    output logic [PCMD_OPT_W-1:0]                     oPM_PCommandOption,
    output logic [NumberOfWays-1:0]                   oPM_TargetWay,
    output logic [NUM_DATA_W-1:0]                     oPM_NumOfData,
    output logic                                      oPM_CASelect,
    output logic [7:0]                                oPM_CAData,
    input  logic [7:0]                                iPM_Ready,
    input  logic [7:0]                                iPM_LastStep,
    input  logic [31:0]                               iPM_ReadData,
    input  logic                                      iPM_ReadValid,
    input  logic                                      iPM_ReadLast,
    output logic                                      oPM_ReadReady
);

    localparam int N = NumberOfExecutors;
    localparam int W = NumberOfWays;

    logic [1:0]   state_q, state_d;
    logic [N-1:0] grant_q, grant_d;
    logic [2:0]   priority_q, priority_d;
    logic [N-1:0] pick_s;
    logic         pick_valid_s;
    logic [7:0]   grant_pad_s;
    logic [2:0]   owner_idx_s;
    logic [2:0]   next_prio_s;
    logic [N-1:0] sel_s;

    npcg_rr_picker #(.N(N)) u_picker (
        .iReq      (iExReq),
        .iPriority (priority_q),
        .oPick     (pick_s),
        .oValid    (pick_valid_s)
    );

    // Owner index and the wrapped priority that follows it.
    always_comb begin
        grant_pad_s = 8'd0;
        for (int k = 0; k < N; k++) begin
            grant_pad_s[k] = grant_q[k];
        end
        owner_idx_s = onehot_to_idx(grant_pad_s);
        if (owner_idx_s == 3'(N - 1)) begin
            next_prio_s = 3'd0;
        end else begin
            next_prio_s = owner_idx_s + 3'd1;
        end
    end

    // Ownership FSM; last-step pulses from non-owners are masked by the grant.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        priority_d = priority_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    grant_d = pick_s;
                    state_d = ST_BUSY;
                end else begin
                    grant_d = {N{1'b0}};
                end
            end
            ST_BUSY: begin
                if (|(iExLastStep & grant_q)) begin
                    grant_d    = {N{1'b0}};
                    priority_d = next_prio_s;
                    state_d    = ST_RELEASE;
                end else if (grant_q == {N{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_RELEASE: begin
                grant_d = {N{1'b0}};
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = {N{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant and priority registers.
    always_ff @(posedge iSystemClock or posedge iReset) begin
        if (iReset) begin
            state_q    <= ST_IDLE;
            grant_q    <= {N{1'b0}};
            priority_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            priority_q <= priority_d;
        end
    end

    assign oExGrant     = grant_q;
    assign oEx_ReadData = iPM_ReadData;

    // AND-OR muxes driven only by the registered grant; zero when nobody owns the PM.
    always_comb begin
        sel_s              = grant_q & {N{state_q == ST_BUSY}};
        oPM_PCommand       = {PCMD_W{1'b0}};
        oPM_PCommandOption = {PCMD_OPT_W{1'b0}};
        oPM_TargetWay      = {W{1'b0}};
        oPM_NumOfData      = {NUM_DATA_W{1'b0}};
        oPM_CASelect       = 1'b0;
        oPM_CAData         = 8'd0;
        oEx_PM_Ready       = {(8*N){1'b0}};
        oEx_PM_LastStep    = {(8*N){1'b0}};
        for (int k = 0; k < N; k++) begin
            oPM_PCommand       = oPM_PCommand | (iEx_PCommand[PCMD_W*k +: PCMD_W] & {PCMD_W{sel_s[k]}});
            oPM_PCommandOption = oPM_PCommandOption |
                                 (iEx_PCommandOption[PCMD_OPT_W*k +: PCMD_OPT_W] & {PCMD_OPT_W{sel_s[k]}});
            oPM_TargetWay      = oPM_TargetWay | (iEx_TargetWay[W*k +: W] & {W{sel_s[k]}});
            oPM_NumOfData      = oPM_NumOfData |
                                 (iEx_NumOfData[NUM_DATA_W*k +: NUM_DATA_W] & {NUM_DATA_W{sel_s[k]}});
            oPM_CASelect       = oPM_CASelect | (iEx_CASelect[k] & sel_s[k]);
            oPM_CAData         = oPM_CAData | (iEx_CAData[8*k +: 8] & {8{sel_s[k]}});
            oEx_PM_Ready[8*k +: 8]    = iPM_Ready & {8{grant_q[k]}};
            oEx_PM_LastStep[8*k +: 8] = iPM_LastStep & {8{grant_q[k]}};
        end
        oEx_ReadValid = grant_q & {N{iPM_ReadValid}};
        oEx_ReadLast  = grant_q & {N{iPM_ReadLast}};
        oPM_ReadReady = |(grant_q & iEx_ReadReady);
    end

endmodule

// File: tb/tb_npcg_toggle_bnc_pm_arbiter.sv
// Self-checking bench for the PM arbiter: cycle vector table with a scoreboard
// queue, plus fairness, read-routing and asynchronous-reset sequences.
module tb_npcg_toggle_bnc_pm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, last, ex_cas, ex_rr;
    logic [31:0] ex_pcmd, ex_ca;
    logic [11:0] ex_opt;
    logic [15:0] ex_way;
    logic [63:0] ex_nod;
    logic [3:0]  grant, rvalid, rlast;
    logic [31:0] ex_pm_ready, ex_pm_last, rdata;
    logic [7:0]  pm_pcmd, pm_ca, pm_ready, pm_last;
    logic [2:0]  pm_opt;
    logic [3:0]  pm_way;
    logic [15:0] pm_nod;
    logic        pm_cas, pm_rvalid, pm_rlast, pm_rready;
    logic [31:0] pm_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    npcg_toggle_bnc_pm_arbiter dut (
        .iSystemClock(clk), .iReset(rst),
        .iExReq(req), .iExLastStep(last), .oExGrant(grant),
        .iEx_PCommand(ex_pcmd), .iEx_PCommandOption(ex_opt), .iEx_TargetWay(ex_way),
        .iEx_NumOfData(ex_nod), .iEx_CASelect(ex_cas), .iEx_CAData(ex_ca),
        .iEx_ReadReady(ex_rr), .oEx_PM_Ready(ex_pm_ready), .oEx_PM_LastStep(ex_pm_last),
        .oEx_ReadData(rdata), .oEx_ReadValid(rvalid), .oEx_ReadLast(rlast),
        .oPM_PCommand(pm_pcmd), .oPM_PCommandOption(pm_opt), .oPM_TargetWay(pm_way),
        .oPM_NumOfData(pm_nod), .oPM_CASelect(pm_cas), .oPM_CAData(pm_ca),
        .iPM_Ready(pm_ready), .iPM_LastStep(pm_last), .iPM_ReadData(pm_rdata),
        .iPM_ReadValid(pm_rvalid), .iPM_ReadLast(pm_rlast), .oPM_ReadReady(pm_rready)
    );

    typedef struct packed {
        logic [3:0]  req;
        logic [3:0]  last;
        logic [31:0] pcmd;
        logic [3:0]  exp_grant;
        logic [7:0]  exp_pcmd;
        logic [31:0] exp_ready;
        logic [7:0]  exp_ca;
    } vec_t;

    typedef struct packed {
        logic [3:0]  grant;
        logic [7:0]  pcmd;
        logic [31:0] ready;
        logic [7:0]  ca;
    } exp_t;

    vec_t        vecs[18];
    exp_t        sb[$];
    logic [31:0] rd_sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'd0;
        last = 4'd0;
        step();
        rst = 1'b0;
    endtask

    function automatic int oh_idx(input logic [3:0] oh);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) r = i;
        end
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   owners[$];
        int   gap, busy_cnt, ngr, idx;
        logic [3:0] prev_g;
        int   exp_order[6];

        rst = 1'b1; req = 4'd0; last = 4'd0; ex_pcmd = 32'd0; ex_opt = 12'd0;
        ex_way = 16'h4321; ex_nod = 64'd0; ex_cas = 4'd0; ex_ca = 32'hD3C2_B1A0;
        ex_rr = 4'd0; pm_ready = 8'h7F; pm_last = 8'h00; pm_rdata = 32'h1234_5678;
        pm_rvalid = 1'b0; pm_rlast = 1'b0;
        #2;
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_pcmd", 32'(pm_pcmd), 32'h0);
        chk("reset_ex_ready", ex_pm_ready, 32'h0);
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        chk("reset_rdata_follows", rdata, 32'h1234_5678);
        step();
        rst = 1'b0;

        //            req     last    pcmd          grant   pcmd   ready          ca
        vecs[0]  = '{4'b0100, 4'b0000, 32'h0040_0000, 4'b0100, 8'h40, 32'h007F_0000, 8'hC2};
        vecs[1]  = '{4'b0100, 4'b0000, 32'h0040_0000, 4'b0100, 8'h40, 32'h007F_0000, 8'hC2};
        vecs[2]  = '{4'b0100, 4'b0100, 32'h0040_0000, 4'b0000, 8'h00, 32'h0000_0000, 8'h00};
        vecs[3]  = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 8'h00, 32'h0000_0000, 8'h00};
        vecs[4]  = '{4'b1001, 4'b0000, 32'h0100_0004, 4'b1000, 8'h01, 32'h7F00_0000, 8'hD3};
        vecs[5]  = '{4'b1001, 4'b1000, 32'h0100_0004, 4'b0000, 8'h00, 32'h0000_0000, 8'h00};
        vecs[6]  = '{4'b1001, 4'b0000, 32'h0100_0004, 4'b0000, 8'h00, 32'h0000_0000, 8'h00};
        vecs[7]  = '{4'b1001, 4'b0000, 32'h0100_0004, 4'b0001, 8'h04, 32'h0000_007F, 8'hA0};
        vecs[8]  = '{4'b1001, 4'b1000, 32'h0800_0004, 4'b0001, 8'h04, 32'h0000_007F, 8'hA0};
        vecs[9]  = '{4'b1001, 4'b0001, 32'h0800_0004, 4'b0000, 8'h00, 32'h0000_0000, 8'h00};
        vecs[10] = '{4'b1111, 4'b0000, 32'h0000_0000, 4'b0000, 8'h00, 32'h0000_0000, 8'h00};
        vecs[11] = '{4'b1111, 4'b0000, 32'h0000_0000, 4'b0010, 8'h00, 32'h0000_7F00, 8'hB1};
        vecs[12] = '{4'b1111, 4'b0010, 32'h0000_0000, 4'b0000, 8'h00, 32'h0000_0000, 8'h00};
        vecs[13] = '{4'b1111, 4'b0000, 32'h0040_0000, 4'b0000, 8'h00, 32'h0000_0000, 8'h00};
        vecs[14] = '{4'b1111, 4'b0000, 32'h0040_0000, 4'b0100, 8'h40, 32'h007F_0000, 8'hC2};
        vecs[15] = '{4'b0000, 4'b0000, 32'h0040_0000, 4'b0100, 8'h40, 32'h007F_0000, 8'hC2};
        vecs[16] = '{4'b0000, 4'b0000, 32'h0040_0000, 4'b0100, 8'h40, 32'h007F_0000, 8'hC2};
        vecs[17] = '{4'b0000, 4'b0100, 32'h0040_0000, 4'b0000, 8'h00, 32'h0000_0000, 8'h00};

        for (int v = 0; v < 18; v++) begin
            req     = vecs[v].req;
            last    = vecs[v].last;
            ex_pcmd = vecs[v].pcmd;
            sb.push_back('{vecs[v].exp_grant, vecs[v].exp_pcmd, vecs[v].exp_ready, vecs[v].exp_ca});
            step();
            e = sb.pop_front();
            chk($sformatf("vec%0d_grant", v), 32'(grant), 32'(e.grant));
            chk($sformatf("vec%0d_pcmd", v), 32'(pm_pcmd), 32'(e.pcmd));
            chk($sformatf("vec%0d_ex_ready", v), ex_pm_ready, e.ready);
            chk($sformatf("vec%0d_ca", v), 32'(pm_ca), 32'(e.ca));
        end
        req = 4'd0; last = 4'd0;

        // Fairness: 0,1,3 request continuously, each finishing 5 cycles into ownership.
        do_reset();
        exp_order = '{0, 1, 3, 0, 1, 3};
        ex_pcmd  = 32'h4342_4140;
        req      = 4'b1011;
        gap      = 0;
        busy_cnt = 0;
        ngr      = 0;
        prev_g   = 4'd0;
        for (int c = 0; c < 200 && ngr < 6; c++) begin
            step();
            if (grant != 4'd0) begin
                if (prev_g == 4'd0) begin
                    idx = oh_idx(grant);
                    owners.push_back(idx);
                    chk($sformatf("fair_pcmd%0d", ngr), 32'(pm_pcmd), 32'(8'h40 + 8'(idx)));
                    if (ngr > 0) chk($sformatf("fair_gap%0d", ngr), 32'(gap), 32'd2);
                    ngr++;
                    busy_cnt = 1;
                end else begin
                    busy_cnt++;
                end
                gap = 0;
            end else begin
                chk("fair_idle_pcmd", 32'(pm_pcmd), 32'h0);
                gap++;
                busy_cnt = 0;
            end
            prev_g = grant;
            last   = (busy_cnt == 5) ? grant : 4'd0;
        end
        chk("fair_grant_count", 32'(ngr), 32'd6);
        for (int i = 0; i < 6 && i < owners.size(); i++) begin
            chk($sformatf("fair_order%0d", i), 32'(owners[i]), 32'(exp_order[i]));
        end
        req = 4'd0; last = 4'd0; ex_pcmd = 32'd0;

        // Read routing: owner 1 receives a 4-word stream.
        do_reset();
        req = 4'b0010;
        step();
        chk("rd_grant", 32'(grant), 32'h2);
        for (int i = 0; i < 4; i++) begin
            pm_rdata  = 32'hA5A5_0000 + 32'(i);
            pm_rvalid = 1'b1;
            pm_rlast  = (i == 3);
            ex_rr     = {2'b00, (i % 2 == 1), 1'b1};
            rd_sb.push_back(32'hA5A5_0000 + 32'(i));
            #1;
            chk($sformatf("rd_valid%0d", i), 32'(rvalid), 32'h2);
            chk($sformatf("rd_last%0d", i), 32'(rlast), (i == 3) ? 32'h2 : 32'h0);
            chk($sformatf("rd_ready%0d", i), 32'(pm_rready), 32'(i % 2 == 1));
            if (rvalid[1] && rd_sb.size() > 0) begin
                chk($sformatf("rd_data%0d", i), rdata, rd_sb.pop_front());
            end
            step();
        end
        chk("rd_sb_empty", 32'(rd_sb.size()), 32'd0);
        pm_rvalid = 1'b0; pm_rlast = 1'b0; ex_rr = 4'd0;

        // Asynchronous reset while executor 2 owns the PM.
        do_reset();
        req     = 4'b0100;
        ex_pcmd = 32'h0040_0000;
        step();
        chk("arst_pre_grant", 32'(grant), 32'h4);
        chk("arst_pre_pcmd", 32'(pm_pcmd), 32'h40);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_grant", 32'(grant), 32'h0);
        chk("arst_pcmd", 32'(pm_pcmd), 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("arst_regrant", 32'(grant), 32'h4);
        do_reset();
        req = 4'b0101;
        step();
        chk("arst_tie_prio0", 32'(grant), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
